fetch_stage: RTL and testbench

- Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of the IF/ID pipeline register.
- Owns the PC register, next-PC selection (sequential / branch / jump) and a request/acknowledge handshake to an instruction memory with variable latency.
- Presents InstrF and PCPlus4F to the IF/ID register, plus ValidF so the hazard unit can insert a bubble while memory is busy.

---
 rtl/fetch_stage.sv | 114 +++++++++++
 tb/tb_fetch_stage.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, picks the next PC and runs a req/ack
// handshake with a variable-latency instruction memory.
module fetch_stage #(
    parameter int unsigned      WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             StallF,
    input  logic             PCSrcD,
    input  logic [WIDTH-1:0] PCBranchD,
    input  logic             JumpD,
    input  logic [WIDTH-1:0] PCJumpD,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ack,
    input  logic [WIDTH-1:0] imem_rdata,
    output logic [WIDTH-1:0] PCF,
    output logic [WIDTH-1:0] PCPlus4F,
    output logic [WIDTH-1:0] InstrF,
    output logic             ValidF
);

    localparam logic [WIDTH-1:0] PcStep    = WIDTH'(4);
    localparam logic [WIDTH-1:0] AlignMask = {{(WIDTH-2){1'b1}}, 2'b00};

    typedef enum logic [1:0] {StReq, StWait, StHold, StDrop} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic [WIDTH-1:0] pc_plus4;
    logic [WIDTH-1:0] target;
    logic             redirect;

    assign pc_plus4  = pc_q + PcStep;
    // A stalled fetch ignores decode redirects; they are re-presented later.
    assign redirect  = (JumpD | PCSrcD) & ~StallF;
    assign target    = (JumpD ? PCJumpD : PCBranchD) & AlignMask;

    assign PCF       = pc_q;
    assign PCPlus4F  = pc_plus4;
    assign imem_addr = addr_q;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        addr_d   = addr_q;
        hold_d   = hold_q;
        imem_req = 1'b1;
        ValidF   = 1'b0;
        InstrF   = imem_rdata;
        unique case (state_q)
            StReq, StWait: begin
                ValidF = imem_ack;
                if (redirect) begin
                    pc_d = target;
                    if (imem_ack) begin
                        addr_d  = target;
                        state_d = StReq;
                    end else begin
                        state_d = StDrop;
                    end
                end else if (imem_ack && !StallF) begin
                    pc_d    = pc_plus4;
                    addr_d  = pc_plus4;
                    state_d = StReq;
                end else if (imem_ack) begin
                    hold_d  = imem_rdata;
                    state_d = StHold;
                end else begin
                    state_d = StWait;
                end
            end
            StHold: begin
                imem_req = 1'b0;
                ValidF   = 1'b1;
                InstrF   = hold_q;
                if (!StallF) begin
                    pc_d    = redirect ? target : pc_plus4;
                    addr_d  = pc_d;
                    state_d = StReq;
                end
            end
            StDrop: begin
                if (redirect) begin
                    pc_d = target;
                end
                // The wrong-path response is discarded; then fetch the latest PC.
                if (imem_ack) begin
                    addr_d  = pc_d;
                    state_d = StReq;
                end
            end
            default: state_d = StReq;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StReq;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            hold_q  <= hold_d;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios with literal expectations, then
// randomized traffic against a behavioural model and a variable-latency memory.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset, StallF, PCSrcD, JumpD, imem_ack;
    logic [31:0] PCBranchD, PCJumpD, imem_rdata;
    logic        imem_req, ValidF;
    logic [31:0] imem_addr, PCF, PCPlus4F, InstrF;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_stage #(
        .WIDTH    (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .StallF     (StallF),
        .PCSrcD     (PCSrcD),
        .PCBranchD  (PCBranchD),
        .JumpD      (JumpD),
        .PCJumpD    (PCJumpD),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .PCF        (PCF),
        .PCPlus4F   (PCPlus4F),
        .InstrF     (InstrF),
        .ValidF     (ValidF)
    );

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_3C3C;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: the PC, the address being requested, and whether a
    // fetched word is parked (holding) or a wrong-path response is awaited (dropping).
    logic        m_init = 1'b0;
    logic        m_hold = 1'b0;
    logic        m_drop = 1'b0;
    logic [31:0] m_pc, m_addr, m_held;
    logic        m_redir;
    logic [31:0] m_tgt, m_hold_npc, m_drop_npc;
    logic        e_valid;
    logic [31:0] e_instr;

    assign m_redir    = !StallF && (JumpD || PCSrcD);
    assign m_tgt      = (JumpD ? PCJumpD : PCBranchD) & 32'hFFFF_FFFC;
    assign m_hold_npc = m_redir ? m_tgt : m_pc + 32'd4;
    assign m_drop_npc = m_redir ? m_tgt : m_pc;
    assign e_valid    = m_hold || (!m_drop && imem_ack);
    assign e_instr    = m_hold ? m_held : imem_rdata;

    always @(posedge clk) begin
        if (reset) begin
            m_init <= 1'b1;
            m_pc   <= 32'h0;
            m_addr <= 32'h0;
            m_hold <= 1'b0;
            m_drop <= 1'b0;
        end else if (m_init) begin
            if (m_hold) begin
                if (!StallF) begin
                    m_pc   <= m_hold_npc;
                    m_addr <= m_hold_npc;
                    m_hold <= 1'b0;
                end
            end else if (m_drop) begin
                m_pc <= m_drop_npc;
                if (imem_ack) begin
                    m_addr <= m_drop_npc;
                    m_drop <= 1'b0;
                end
            end else if (m_redir) begin
                m_pc <= m_tgt;
                if (imem_ack) m_addr <= m_tgt;
                else m_drop <= 1'b1;
            end else if (imem_ack && !StallF) begin
                m_pc   <= m_pc + 32'd4;
                m_addr <= m_pc + 32'd4;
            end else if (imem_ack) begin
                m_hold <= 1'b1;
                m_held <= imem_rdata;
            end
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            chk("imem_req", 32'(imem_req), 32'(!m_hold));
            if (!m_hold) chk("imem_addr", imem_addr, m_addr);
            chk("PCF", PCF, m_pc);
            chk("PCPlus4F", PCPlus4F, m_pc + 32'd4);
            chk("ValidF", 32'(ValidF), 32'(e_valid));
            if (e_valid) chk("InstrF", InstrF, e_instr);
        end
    end

    task automatic drive(input logic rst, input logic st, input logic br,
                         input logic [31:0] pb, input logic jp, input logic [31:0] pj,
                         input logic ak, input logic [31:0] rd);
        reset      = rst;
        StallF     = st;
        PCSrcD     = br;
        PCBranchD  = pb;
        JumpD      = jp;
        PCJumpD    = pj;
        imem_ack   = ak;
        imem_rdata = rd;
        @(negedge clk);
    endtask

    task automatic drv(input logic ak, input logic [31:0] rd);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, ak, rd);
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    int          mem_cnt, lat;
    logic        ak, rst;
    logic [31:0] rd;

    initial begin
        reset = 1'b1; StallF = 1'b0; PCSrcD = 1'b0; JumpD = 1'b0; imem_ack = 1'b0;
        PCBranchD = 32'h0; PCJumpD = 32'h0; imem_rdata = 32'h0;
        advance();

        // Reset state
        drv(1'b0, 32'h0);
        chk("rst_PCF", PCF, 32'h0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_req", 32'(imem_req), 32'd1);
        chk("rst_valid", 32'(ValidF), 32'd0);
        advance();

        // Zero-wait memory returning address as data
        for (int k = 0; k < 4; k++) begin
            drv(1'b1, imem_addr);
            chk("zw_PCF", PCF, 32'(4 * k));
            chk("zw_PCPlus4F", PCPlus4F, 32'(4 * k + 4));
            chk("zw_valid", 32'(ValidF), 32'd1);
            chk("zw_instr", InstrF, 32'(4 * k));
            advance();
        end

        // Two wait states
        for (int i = 0; i < 3; i++) begin
            drv(i == 2, 32'h1234_5678);
            chk("ws_addr", imem_addr, 32'h10);
            chk("ws_req", 32'(imem_req), 32'd1);
            chk("ws_valid", 32'(ValidF), 32'(i == 2));
            chk("ws_PCF", PCF, 32'h10);
            advance();
        end
        chk("ws_PCF_after", PCF, 32'h14);

        // Ack under stall parks the word
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h8C22_0004);
        chk("st_valid0", 32'(ValidF), 32'd1);
        advance();
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'hFFFF_FFFF);
            chk("st_req", 32'(imem_req), 32'd0);
            chk("st_instr", InstrF, 32'h8C22_0004);
            chk("st_valid", 32'(ValidF), 32'd1);
            chk("st_PCF", PCF, 32'h14);
            advance();
        end
        drv(1'b0, 32'hFFFF_FFFF);
        chk("st_rel_PCF", PCF, 32'h14);
        chk("st_rel_instr", InstrF, 32'h8C22_0004);
        advance();
        chk("st_adv_PCF", PCF, 32'h18);
        chk("st_adv_addr", imem_addr, 32'h18);

        // Branch while waiting: wrong-path response is dropped
        drv(1'b0, 32'h0);
        advance();
        drive(1'b0, 1'b0, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("br_PCF_pre", PCF, 32'h18);
        advance();
        chk("br_PCF", PCF, 32'h40);
        drv(1'b0, 32'h0);
        chk("dr_valid0", 32'(ValidF), 32'd0);
        chk("dr_addr0", imem_addr, 32'h18);
        advance();
        drv(1'b1, 32'hDEAD_BEEF);
        chk("dr_valid1", 32'(ValidF), 32'd0);
        chk("dr_addr1", imem_addr, 32'h18);
        advance();
        chk("dr_next_addr", imem_addr, 32'h40);
        chk("dr_next_PCF", PCF, 32'h40);

        // Jump beats branch; target alignment; wrap-around
        drive(1'b0, 1'b0, 1'b1, 32'h80, 1'b1, 32'h103, 1'b1, 32'h0);
        advance();
        chk("jp_PCF", PCF, 32'h100);
        chk("jp_addr", imem_addr, 32'h100);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFE, 1'b1, 32'h0);
        advance();
        chk("wrap_PCF", PCF, 32'hFFFF_FFFC);
        chk("wrap_PCPlus4F", PCPlus4F, 32'h0);
        drv(1'b1, 32'h0);
        advance();
        chk("wrap_next_PCF", PCF, 32'h0);

        // Reset while dropping, stalled across it
        drv(1'b0, 32'h0);
        advance();
        drive(1'b0, 1'b0, 1'b1, 32'h200, 1'b0, 32'h0, 1'b0, 32'h0);
        advance();
        chk("rd_PCF", PCF, 32'h200);
        drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        advance();
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("rd_PCF_rst", PCF, 32'h0);
        chk("rd_valid", 32'(ValidF), 32'd0);
        chk("rd_addr", imem_addr, 32'h0);
        chk("rd_req", 32'(imem_req), 32'd1);
        advance();

        // Randomized traffic against a variable-latency memory
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        advance();
        mem_cnt = 0;
        lat = $urandom_range(0, 3);
        for (int n = 0; n < 3000; n++) begin
            ak  = imem_req && (mem_cnt >= lat);
            rd  = ak ? memfn(imem_addr) : $urandom;
            rst = ($urandom_range(0, 199) == 0);
            drive(rst, $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, $urandom,
                  $urandom_range(0, 11) == 0, $urandom, ak, rd);
            if (rst || (imem_req && ak)) begin
                mem_cnt = 0;
                lat = $urandom_range(0, 3);
            end else if (imem_req) begin
                mem_cnt++;
            end
            advance();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
